rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter that shares the register file's single write port between N writeback requesters (ALU result, data-memory load, host/debug loader). Each requester uses a valid/ready handshake. The winning request is registered into a one-deep issue stage that drives the register file's write enable, write address and write data. A per-register pending bitmap tells the control unit which registers hold an issued but not yet committed write.

## Interface
- W, 8: data path width; matches the register file.
- D, 4: register address width; register file depth is 2**D.
- N, 3: number of requesters, 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  bit i: requester i presents a write.
- req_addr  in  N*D  slice [i*D +: D]: target register of requester i.
- req_data  in  N*W  slice [i*W +: W]: write data of requester i.
- req_ready  out  N  one-hot or zero; bit i: request i accepted this edge.
- stall  in  1  freezes arbitration; no grant while high.
- write_en  out  1  to register file write_en.
- w_addr  out  D  to register file w_addr.
- w_data  out  W  to register file data_in.
- grant_id  out  3  index of the requester that owns the current issue slot.
- pending  out  2**D  bit r set while a write to register r sits in the issue stage.

## Operation
- **Arbitration (combinational):**
  - Search req_valid starting at pointer ptr (0..N-1), ascending with wrap.
  - The first set bit is the winner.
  - req_ready = one-hot(winner) when stall=0 and any valid; otherwise 0.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- **Handshake:** a transfer happens at the edge where req_valid[i] && req_ready[i].
  - A requester holds valid, addr and data stable until accepted.
  - Valid is never withdrawn before acceptance; the bench checks this.
- **Issue stage (registered):**
  - On a transfer: write_en<=1, w_addr<=req_addr[winner], w_data<=req_data[winner], grant_id<=winner.
  - On no transfer: write_en<=0; w_addr, w_data and grant_id hold their values.
- **Pointer update:**
  - On a transfer: ptr<=(winner+1) mod N.
  - Otherwise ptr holds.
  - Any continuously-valid requester is granted within N transfers.
- **Pending:** pending = write_en ? onehot(w_addr) : 0. This output is decoded from registers.
- **Same-address conflict:** two requesters valid for the same address are served in round-robin order, one per cycle. The later grant's data is the final register value.
- **Register 0 writes:** not filtered. Writes to R0 and R7, the branch-compare registers, are issued like any other write.
- **Stall:**
  - A request already in the issue stage completes: write_en is still 1 for that cycle.
  - No new grant while stall is high, so write_en drops to 0 in the next cycle.

## Timing
- **Reset (rst_n low, asynchronous):**
  - write_en=0, w_addr=0, w_data=0, grant_id=0, ptr=0, pending=0.
  - req_ready=0 while rst_n is low.
- **Latency:**
  - A request accepted at edge E0 appears on write_en/w_addr/w_data during cycle E0..E1.
  - The register file captures it at E1.
  - Combinational reads show the new value after E1.
- **Throughput:** one write per cycle at most; back-to-back grants are allowed every cycle.
- **pending[r]:** high exactly in cycle E0..E1 for a write accepted at E0.
- **Reset asserted mid-operation:** the issue-stage write is discarded and outputs clear immediately. No partial write reaches the register file after rst_n falls.
- **Simultaneous stall rise and valid:** stall wins and no transfer occurs.
- **Pointer wrap:** a winner of N-1 sets ptr to 0.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with req_valid=3'b111 -> all outputs 0 immediately. After release, the first grant goes to requester 0.
- **Single requester:** req1 valid, addr=4'h5, data=8'hA3 -> req_ready=3'b010 at E0. write_en=1, w_addr=5, w_data=A3, pending=16'h0020 during E0..E1. At E1, RegFile[5]=A3.
- **Full contention:** req_valid=3'b111 held for 6 cycles -> grants 0,1,2,0,1,2, write_en continuously 1, ptr wraps to 0.
- **Same-address conflict:** req0 addr=7 data=11 and req2 addr=7 data=22, both valid, ptr=0 -> req0 granted first, then req2. Final RegFile[7]=22.
- **Stall:** req0 valid with stall=1 for 3 cycles -> req_ready=0 and write_en=0 throughout. Stall drops -> grant the next edge, data unchanged.
- **Fairness:** req0 always valid and req2 asserted once -> req2 granted within 2 transfers. Hold-stable protocol checks pass.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter that shares the register file's single write port
// between N writeback requesters. The winning request is captured in a
// one-deep issue stage that drives write_en/w_addr/w_data. The pending
// bitmap is decoded from that stage for the control unit.
module rf_write_arbiter #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*D-1:0]   req_addr,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  input  logic             stall,
  output logic             write_en,
  output logic [D-1:0]     w_addr,
  output logic [W-1:0]     w_data,
  output logic [2:0]       grant_id,
  output logic [2**D-1:0]  pending
);

  // Index width wide enough for 0..N-1. The sum width has one extra bit so
  // the wrap of ptr + offset can be detected before reducing modulo N.
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [D-1:0]  addr_arr [N];
  logic [W-1:0]  data_arr [N];

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] winner;
  logic          found;
  logic          transfer;

  // Unpack the flat request buses into per-requester views.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*D +: D];
      assign data_arr[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // Search req_valid from ptr upward with wrap; the first set bit wins.
  always_comb begin
    logic [IW:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_reg} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!found && req_valid[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  // A grant needs a valid request, no stall and reset released; stall
  // therefore always beats a simultaneously rising valid.
  always_comb begin
    transfer  = found && !stall && rst_n;
    req_ready = '0;
    if (transfer) begin
      req_ready[winner] = 1'b1;
    end
  end

  // The pointer moves just past the winner so every valid requester is
  // reached within N transfers; winner N-1 wraps back to 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (transfer) begin
      if (winner == IW'(N-1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = winner + IW'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Issue stage: capture the winner on a transfer, otherwise drop write_en
  // and keep address/data/id so the register file port stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      grant_id <= '0;
    end else if (transfer) begin
      write_en <= 1'b1;
      w_addr   <= addr_arr[winner];
      w_data   <= data_arr[winner];
      grant_id <= 3'(winner);
    end else begin
      write_en <= 1'b0;
    end
  end

  // Pending bitmap: one-hot of the register currently being written.
  always_comb begin
    pending = '0;
    if (write_en) begin
      pending[w_addr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: per-requester queues drive the
// valid/ready handshake, a round-robin model predicts every cycle, and
// directed scenarios pin the model with literal expectations.
module tb_rf_write_arbiter;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*D-1:0]   req_addr = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             write_en;
  logic [D-1:0]     w_addr;
  logic [W-1:0]     w_data;
  logic [2:0]       grant_id;
  logic [2**D-1:0]  pending;

  rf_write_arbiter #(.W(W), .D(D), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .write_en(write_en), .w_addr(w_addr), .w_data(w_data),
    .grant_id(grant_id), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } req_t;

  typedef struct {
    int gid;
    int addr;
    int data;
    int pend;
    int cyc;
  } log_t;

  req_t q0[$];
  req_t q1[$];
  req_t q2[$];
  log_t log_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fair_wait = 0;
  logic [W-1:0] rf [2**D];
  logic [N-1:0] acc_next = '0;

  // model state
  logic         m_we = 1'b0;
  logic [D-1:0] m_addr = '0;
  logic [W-1:0] m_data = '0;
  int           m_gid = 0;
  int           m_ptr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic push(input int i, input int a, input int d);
    req_t r;
    r.addr = D'(a);
    r.data = W'(d);
    case (i)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  // Behavioural model: who wins and what the issue stage holds next.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_gid <= 0; m_ptr <= 0;
    end else begin
      int w;
      w = rr_winner(req_valid, m_ptr);
      if (!stall && w >= 0) begin
        m_we   <= 1'b1;
        m_addr <= req_addr[w*D +: D];
        m_data <= req_data[w*W +: W];
        m_gid  <= w;
        m_ptr  <= (w + 1) % N;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // Compare process: mid-cycle check of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      logic [N-1:0] er;
      logic [2**D-1:0] ep;
      w  = rr_winner(req_valid, m_ptr);
      er = '0;
      if (!stall && w >= 0) er[w] = 1'b1;
      ep = '0;
      if (m_we) ep[m_addr] = 1'b1;
      check("req_ready", req_ready, er);
      check("write_en", write_en, m_we);
      check("w_addr", w_addr, m_addr);
      check("w_data", w_data, m_data);
      check("grant_id", grant_id, m_gid);
      check("pending", pending, ep);
      if (req_valid[2] && !req_ready[2] && req_ready != '0) fair_wait++;
      acc_next = req_valid & req_ready;
      if (write_en) begin
        log_q.push_back('{int'(grant_id), int'(w_addr), int'(w_data), int'(pending), cyc});
        rf[w_addr] = w_data;
      end
    end else begin
      acc_next = '0;
    end
  end

  // Requester agents: pop accepted heads, present the next ones, and
  // confirm that un-accepted requests stay stable.
  always @(posedge clk) begin
    logic [N-1:0]   acc;
    logic [N-1:0]   prev_v;
    logic [N*D-1:0] prev_a;
    logic [N*W-1:0] prev_d;
    acc = acc_next;
    prev_v = req_valid; prev_a = req_addr; prev_d = req_data;
    cyc++;
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    if (acc[2]) void'(q2.pop_front());
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1; req_addr[0*D +: D] = q0[0].addr; req_data[0*W +: W] = q0[0].data;
    end else req_valid[0] = 1'b0;
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1; req_addr[1*D +: D] = q1[0].addr; req_data[1*W +: W] = q1[0].data;
    end else req_valid[1] = 1'b0;
    if (q2.size() > 0) begin
      req_valid[2] = 1'b1; req_addr[2*D +: D] = q2[0].addr; req_data[2*W +: W] = q2[0].data;
    end else req_valid[2] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (prev_v[i] && !acc[i]) begin
        check("hold_valid", req_valid[i], 1);
        check("hold_addr", req_addr[i*D +: D], prev_a[i*D +: D]);
        check("hold_data", req_data[i*W +: W], prev_d[i*W +: W]);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size() > 0 || req_valid != '0 || write_en) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("idle_within_budget", n < 300, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pos;
    int n0;
    for (int r = 0; r < 2**D; r++) rf[r] = '0;

    // Reset state.
    #12;
    check("rst_write_en", write_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_pending", pending, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cycles(2);

    // Full contention from ptr 0: 0,1,2,0,1,2 back to back.
    log_q.delete();
    push(0, 1, 'h10); push(1, 2, 'h20); push(2, 3, 'h30);
    push(0, 4, 'h40); push(1, 5, 'h50); push(2, 6, 'h60);
    wait_idle();
    check("cont_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check("cont_gid", log_q[k].gid, k % 3);
        check("cont_data", log_q[k].data, (k + 1) * 'h10);
        check("cont_back_to_back", log_q[k].cyc, log_q[0].cyc + k);
      end
    end

    // Same-address conflict with ptr 0: req0 then req2, last write wins.
    log_q.delete();
    push(0, 7, 'h11); push(2, 7, 'h22);
    wait_idle();
    check("conf_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("conf_first_gid", log_q[0].gid, 0);
      check("conf_first_data", log_q[0].data, 'h11);
      check("conf_second_gid", log_q[1].gid, 2);
      check("conf_second_data", log_q[1].data, 'h22);
    end
    check("conf_rf7", rf[7], 'h22);

    // Single requester 1 to register 5.
    log_q.delete();
    push(1, 5, 'hA3);
    wait_idle();
    check("single_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("single_gid", log_q[0].gid, 1);
      check("single_addr", log_q[0].addr, 5);
      check("single_data", log_q[0].data, 'hA3);
      check("single_pending", log_q[0].pend, 'h0020);
    end
    check("single_rf5", rf[5], 'hA3);

    // Stall holds off a waiting request; grant follows the stall drop.
    @(posedge clk);
    #2 stall = 1'b1;
    push(0, 9, 'h5C);
    repeat (4) begin
      @(negedge clk);
      check("stall_ready", req_ready, 0);
      check("stall_write_en", write_en, 0);
    end
    check("stall_valid_presented", req_valid, 3'b001);
    @(posedge clk);
    #2 stall = 1'b0;
    @(negedge clk);
    check("unstall_ready", req_ready, 3'b001);
    @(negedge clk);
    check("unstall_write_en", write_en, 1);
    check("unstall_w_addr", w_addr, 9);
    check("unstall_w_data", w_data, 'h5C);
    check("unstall_grant_id", grant_id, 0);
    wait_idle();

    // Fairness: req0 streams, req2 arrives once and is served promptly.
    log_q.delete();
    fair_wait = 0;
    for (int k = 0; k < 6; k++) push(0, 1, k);
    wait_cycles(3);
    push(2, 'hE, 'hEE);
    wait_idle();
    pos = -1;
    n0 = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k].gid == 2 && pos < 0) pos = k;
      if (log_q[k].gid == 0) n0++;
    end
    check("fair_req2_granted", pos >= 0, 1);
    check("fair_within_2", fair_wait <= 1, 1);
    check("fair_req0_all", n0, 6);
    if (pos >= 0) check("fair_req2_data", log_q[pos].data, 'hEE);

    // Reset mid-stream with all three requesters valid.
    for (int k = 0; k < 3; k++) begin
      push(0, 'hA, k); push(1, 'hB, k); push(2, 'hC, k);
    end
    wait_cycles(3);
    check("mid_busy_write_en", write_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write_en", write_en, 0);
    check("mid_rst_w_addr", w_addr, 0);
    check("mid_rst_w_data", w_data, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_write_en", write_en, 0);
    @(posedge clk);
    log_q.delete();
    #3 rst_n = 1'b1;
    wait_idle();
    check("post_rst_nonempty", log_q.size() > 0, 1);
    if (log_q.size() > 0) check("post_rst_first_gid", log_q[0].gid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
